// File: rtl/serial_lane_packer_if.sv
// Bus bundle for serial_lane_packer: serial coefficient input side and parallel frame output side.
interface serial_lane_packer_if #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 32
);
  logic                                      in_valid;
  logic                                      in_start;
  logic [DATA_WIDTH_PER_INPUT-1:0]           in_data;
  logic                                      out_valid;
  logic                                      out_start;
  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] out_data;
  logic                                      err_misalign;

  modport master (
    output in_valid, in_start, in_data,
    input  out_valid, out_start, out_data, err_misalign
  );

  modport slave (
    input  in_valid, in_start, in_data,
    output out_valid, out_start, out_data, err_misalign
  );
endinterface

// File: rtl/serial_lane_packer.sv
// Serial-to-parallel packer: one coefficient per accepted word into INPUT_PER_CYCLE-lane frames.
// Build macro SERIAL_LANE_PACKER_FLUSH_EN: emit the partial frame on a misaligned in_start.
module serial_lane_packer #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int FRAMES_PER_BLOCK     = 16
) (
  input logic                 clk,
  input logic                 rst,
  serial_lane_packer_if.slave bus
);
  localparam int W       = DATA_WIDTH_PER_INPUT;
  localparam int LANE_W  = $clog2(INPUT_PER_CYCLE);
  localparam int FRAME_W = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;
  localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(INPUT_PER_CYCLE - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_BLOCK - 1);

  typedef enum logic {ST_UNSYNCED, ST_SYNCED} state_t;

  state_t                        state_q, state_d;
  logic [LANE_W-1:0]             lane_idx;
  logic [FRAME_W-1:0]            frame_idx, frame_base, frame_next;
  logic [W-1:0]                  buffer [INPUT_PER_CYCLE];
  logic                          accept, misalign, complete;
  logic [INPUT_PER_CYCLE*W-1:0]  full_frame;
`ifdef SERIAL_LANE_PACKER_FLUSH_EN
  logic [INPUT_PER_CYCLE*W-1:0]  partial_frame;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_UNSYNCED;
    else     state_q <= state_d;
  end

  // Words are dropped until the first in_start; an in_start always restarts frame numbering.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    misalign   = 1'b0;
    complete   = 1'b0;
    frame_base = frame_idx;
    frame_next = '0;
    if (bus.in_valid && bus.in_start) state_d = ST_SYNCED;
    accept     = bus.in_valid && ((state_q == ST_SYNCED) || bus.in_start);
    misalign   = accept && bus.in_start && (lane_idx != '0);
    complete   = accept && !misalign && (lane_idx == LAST_LANE);
    if (bus.in_start) frame_base = '0;
    frame_next = (frame_base == LAST_FRAME) ? '0 : frame_base + FRAME_W'(1);
  end

  // The final lane bypasses the buffer so the frame leaves one cycle after its last word.
  always_comb begin
    full_frame = '0;
    for (int k = 0; k < INPUT_PER_CYCLE; k++) begin
      full_frame[k*W +: W] = (k == INPUT_PER_CYCLE - 1) ? bus.in_data : buffer[k];
    end
  end

`ifdef SERIAL_LANE_PACKER_FLUSH_EN
  always_comb begin
    partial_frame = '0;
    for (int k = 0; k < INPUT_PER_CYCLE; k++) begin
      if (LANE_W'(k) < lane_idx) partial_frame[k*W +: W] = buffer[k];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx         <= '0;
      frame_idx        <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_start    <= 1'b0;
      bus.out_data     <= '0;
      bus.err_misalign <= 1'b0;
      for (int k = 0; k < INPUT_PER_CYCLE; k++) buffer[k] <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_start <= 1'b0;
      if (misalign) begin
        // The new word becomes lane 0 of frame 0, so the next full frame carries out_start.
        bus.err_misalign <= 1'b1;
        lane_idx         <= LANE_W'(1);
        frame_idx        <= '0;
        buffer[0]        <= bus.in_data;
`ifdef SERIAL_LANE_PACKER_FLUSH_EN
        for (int k = 1; k < INPUT_PER_CYCLE; k++) buffer[k] <= '0;
        bus.out_valid <= 1'b1;
        bus.out_data  <= partial_frame;
`endif
      end else if (accept) begin
        buffer[lane_idx] <= bus.in_data;
        lane_idx         <= lane_idx + LANE_W'(1);
        if (complete) begin
          bus.out_valid <= 1'b1;
          bus.out_start <= (frame_base == '0);
          bus.out_data  <= full_frame;
          frame_idx     <= frame_next;
        end else begin
          frame_idx <= frame_base;
        end
      end
    end
  end
endmodule

// File: doc/serial_lane_packer.md
# serial_lane_packer

Serial-to-parallel packer that gathers one `DATA_WIDTH_PER_INPUT`-bit coefficient per valid cycle into full `INPUT_PER_CYCLE`-lane frames for the 32-lane NTT datapath. It is the receive-side counterpart of the lane unpacker that serializes datapath output one word per cycle. It sits between the narrow board/host interface and the first NTT stage. It also regenerates the stage-level `out_start` pulse that marks the first frame of each polynomial block.

## Interface
Parameters:
- `DATA_WIDTH_PER_INPUT`, 28: coefficient width.
- `INPUT_PER_CYCLE`, 32: lanes per frame; must be a power of two ≥ 2.
- `FRAMES_PER_BLOCK`, 16: frames per polynomial (512 / 32); must be a power of two ≥ 1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_start`, input, 1: qualified by `in_valid`; the word is coefficient 0 of a new block.
- `in_data`, input, `DATA_WIDTH_PER_INPUT`: serial coefficient.
- `out_valid`, output, 1: one-cycle pulse; `out_data` holds a frame.
- `out_start`, output, 1: one-cycle pulse with `out_valid` on frame 0 of a block.
- `out_data`, output, `INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT`: lane k occupies bits [k*W +: W].
- `err_misalign`, output, 1: sticky; `in_start` arrived with lane index ≠ 0.

## Operation
- State:
  - `lane_idx`: log2(INPUT_PER_CYCLE) bits.
  - `frame_idx`: log2(FRAMES_PER_BLOCK) bits, minimum 1 bit.
  - Lane buffer of `INPUT_PER_CYCLE` words.
  - `synced` flag, set by the first `in_start`.
- Accepted word: `in_valid`=1 and (`synced`=1 or `in_start`=1). Words before the first `in_start` after reset are dropped silently.
- On an accepted word, `buffer[lane_idx] <= in_data` and `lane_idx` increments, wrapping to 0.
- Frame completion occurs when a word is accepted at `lane_idx` = `INPUT_PER_CYCLE-1`. Then:
  - The output register loads the buffer with the final lane taken directly from `in_data`.
  - `out_valid` is 1 the next cycle.
  - `out_start` is 1 iff `frame_idx` = 0.
  - `frame_idx` increments and wraps.
- `in_start` with `lane_idx`=0: `frame_idx` is forced to 0, so this frame carries `out_start`. This is legal mid-block as well; the block simply restarts.
- `in_start` with `lane_idx`≠0 (misaligned):
  - `err_misalign` is set.
  - `lane_idx` and `frame_idx` restart at 0, and `in_data` is written to lane 0.
  - The partial frame is handled per Configuration.
- Lanes not rewritten since the last emission keep stale contents, except under the flush rule.
- `in_valid`=0 holds all state; gaps of any length are allowed.

## Timing
- Latency: last word of a frame accepted at cycle t produces `out_valid`/`out_data` at t+1.
- Throughput: one frame every `INPUT_PER_CYCLE` accepted words.
- `out_data` holds its value until the next emission.
- No backpressure; the downstream consumer must sample `out_data` on the `out_valid` pulse.
- Reset values: `out_valid`=0, `out_start`=0, `out_data`=0, `err_misalign`=0, `lane_idx`=0, `frame_idx`=0, `synced`=0, buffer=0.
- Reset mid-frame discards the partial frame; no emission follows.
- `rst` takes priority over all inputs in the same cycle.
- With `INPUT_PER_CYCLE`=32, an `in_start` that coincides with frame completion cannot occur. It would imply `lane_idx` = 31 ≠ 0, so the misalign rule applies.

## Configuration
- `SERIAL_LANE_PACKER_FLUSH_EN` defined, on misaligned `in_start`:
  - The partial frame is emitted at t+1 with `out_valid`=1 and `out_start`=0.
  - Lanes [0, `lane_idx`-1] carry buffered words; lanes ≥ `lane_idx` are 0.
  - The buffer is then cleared except lane 0, which takes the new word.
- Macro undefined: the partial frame is discarded and no `out_valid` pulse occurs.
- `err_misalign` behaves identically in both builds.

## Test plan
- Nominal block: after reset, stream 512 valid words 0..511, with `in_start` on word 0 → 16 `out_valid` pulses, each one cycle after word 31+32f. Frame 0 has `out_start`=1 and lane k = k. Frame 15 has lane k = 480+k.
- Gaps: same stream with `in_valid` low every third cycle → identical frames, and each pulse lands one cycle after its last word.
- Pre-sync drop: 5 words with `in_start`=0, then an aligned block → the 5 words are ignored, and frame 0 lane 0 equals the `in_start` word.
- Misalign: 10 words, then `in_start` with value 0xABC, then 31 words →
  - Flush build: partial frame emitted with lanes 0–9 = data, lanes 10–31 = 0, `out_start`=0.
  - Both builds: a full frame with lane 0 = 0xABC and `out_start`=1; `err_misalign`=1 and sticky.
- Reset mid-frame: reset after 20 words, then an aligned block → no stray `out_valid`, `err_misalign`=0, and the first frame is correct with `out_start`=1.
- Block restart: `in_start` on word 64 of a block → frame 2 is emitted with `out_start`=1, and `frame_idx` continues from 1.
